syn_fifo_flags: RTL

//  Single-clock FIFO for same-domain buffering between pipeline stages.

---
 rtl/syn_fifo_flags.sv | 111 +++++++++++
 1 files changed

// File: rtl/syn_fifo_flags.sv
// Single-clock FIFO with registered occupancy count, threshold flags,
// sticky overflow/underflow, synchronous clear and optional fall-through read.
module syn_fifo_flags #(
   parameter int DLY        = 1,
   parameter int WIDTH_FIFO = 8,
   parameter int ADDR_FIFO  = 3,
   parameter int DEPTH_FIFO = 1 << ADDR_FIFO,
   parameter int AFULL_TH   = DEPTH_FIFO - 2,
   parameter int AEMPTY_TH  = 2,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  wen,
   input  logic [WIDTH_FIFO-1:0] wdata,
   input  logic                  ren,
   output logic [WIDTH_FIFO-1:0] rdata,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_FIFO:0]    count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int PW = ADDR_FIFO + 1;
   localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH_FIFO);
   localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
   localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

   if (DLY < 0 || AEMPTY_TH < 0 || AEMPTY_TH >= AFULL_TH ||
       AFULL_TH > DEPTH_FIFO || DEPTH_FIFO != (1 << ADDR_FIFO)) begin : g_bad_param
      $error("syn_fifo_flags: illegal parameter combination");
   end

   logic [WIDTH_FIFO-1:0] mem [DEPTH_FIFO];
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic [PW-1:0]         wptr_nx;
   logic [PW-1:0]         rptr_nx;
   logic [PW-1:0]         count_nx;
   logic                  wacc;
   logic                  racc;

   assign wacc = wen && !full;
   assign racc = ren && !empty;

   always_comb begin
      wptr_nx  = wacc ? wptr + PW'(1) : wptr;
      rptr_nx  = racc ? rptr + PW'(1) : rptr;
      count_nx = wptr_nx - rptr_nx;
   end

   // Flags are registered from the next count so they never decode glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else if (clr) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wptr         <= wptr_nx;
         rptr         <= rptr_nx;
         count        <= count_nx;
         empty        <= (count_nx == '0);
         full         <= (count_nx == DEPTH_C);
         almost_empty <= (count_nx <= AEMPTY_C);
         almost_full  <= (count_nx >= AFULL_C);
         overflow     <= overflow  | (wen && full);
         underflow    <= underflow | (ren && empty);
      end
   end

   always_ff @(posedge clk) begin
      if (wacc && !clr) begin
         mem[wptr[ADDR_FIFO-1:0]] <= wdata;
      end
   end

   if (FWFT != 0) begin : g_fwft
      assign rdata = mem[rptr[ADDR_FIFO-1:0]];
   end else begin : g_std
      logic [WIDTH_FIFO-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata_q <= '0;
         end else if (racc && !clr) begin
            rdata_q <= mem[rptr[ADDR_FIFO-1:0]];
         end
      end
      assign rdata = rdata_q;
   end

endmodule
